// File: rtl/ao_ini_seq.sv
// Initialization sequencer: copies one configuration word per channel from the
// config RAM into each channel register, verifies the readback, and retries.
module ao_ini_seq #(
  parameter int CH_NUM = 8,
  parameter int ADDR_W = 4,
  parameter int TO_CYC = 1000,
  parameter int RETRY  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ini_start,
  output logic              o_ini_done,
  output logic              o_ini_fail,
  output logic              o_busy,
  output logic [ADDR_W-1:0] om_cfg_raddr,
  output logic              o_cfg_rd,
  input  logic [15:0]       im_cfg_rdata,
  output logic [ADDR_W-1:0] om_ch_sel,
  output logic [15:0]       om_ch_wdata,
  output logic              o_ch_wr_req,
  input  logic              i_ch_wr_ack,
  input  logic [15:0]       im_ch_rback,
  output logic [ADDR_W-1:0] om_fail_ch,
  output logic [1:0]        om_fail_code,
  output logic [3:0]        o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_WAIT, S_WR, S_CHK, S_RETRY_CHK, S_NEXT, S_DONE, S_FAIL
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(CH_NUM - 1);
  localparam logic [15:0]       TO_LAST   = 16'(TO_CYC - 1);
  localparam logic [7:0]        RETRY_MAX = 8'(RETRY);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_MISMAT  = 2'b10;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [7:0]          retry_q, retry_d;
  logic [15:0]         to_q, to_d;
  logic [1:0]          code_q, code_d;
  logic [15:0]         rback_q, rback_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   sel_q, sel_d;
  logic [ADDR_W-1:0]   fail_ch_q, fail_ch_d;
  logic [1:0]          fail_code_q, fail_code_d;
  logic                rd_q, req_q, done_q, fail_q, busy_q;

  // Write handshake: o_ch_wr_req is a level held for every WR cycle; the
  // transfer completes in the first cycle where req and i_ch_wr_ack are both
  // high, and im_ch_rback is captured in that same cycle. Ack is ignored when
  // req is low; ack on the last timeout cycle still completes the transfer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    to_d        = to_q;
    code_d      = code_q;
    rback_d     = rback_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    fail_ch_d   = fail_ch_q;
    fail_code_d = fail_code_q;
    case (state_q)
      S_IDLE: begin
        if (i_ini_start) begin
          idx_d       = '0;
          retry_d     = '0;
          code_d      = CODE_NONE;
          fail_ch_d   = '0;
          fail_code_d = CODE_NONE;
          state_d     = S_RD;
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        wdata_d = im_cfg_rdata;
        sel_d   = idx_q;
        to_d    = '0;
        state_d = S_WR;
      end
      S_WR: begin
        if (i_ch_wr_ack) begin
          rback_d = im_ch_rback;
          state_d = S_CHK;
        end else if (to_q == TO_LAST) begin
          code_d  = CODE_TIMEOUT;
          state_d = S_RETRY_CHK;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      S_CHK: begin
        if (rback_q == wdata_q) begin
          state_d = S_NEXT;
        end else begin
          code_d  = CODE_MISMAT;
          state_d = S_RETRY_CHK;
        end
      end
      S_RETRY_CHK: begin
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 8'd1;
          state_d = S_RD;
        end else begin
          // Failure report is loaded on entry so it is visible with the pulse.
          fail_ch_d   = idx_q;
          fail_code_d = code_q;
          state_d     = S_FAIL;
        end
      end
      S_NEXT: begin
        retry_d = '0;
        code_d  = CODE_NONE;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      to_q        <= '0;
      code_q      <= CODE_NONE;
      rback_q     <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      fail_ch_q   <= '0;
      fail_code_q <= CODE_NONE;
      rd_q        <= 1'b0;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      to_q        <= to_d;
      code_q      <= code_d;
      rback_q     <= rback_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      fail_ch_q   <= fail_ch_d;
      fail_code_q <= fail_code_d;
      rd_q        <= (state_d == S_RD);
      req_q       <= (state_d == S_WR);
      done_q      <= (state_d == S_DONE);
      fail_q      <= (state_d == S_FAIL);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign o_ini_done   = done_q;
  assign o_ini_fail   = fail_q;
  assign o_busy       = busy_q;
  assign om_cfg_raddr = idx_q;
  assign o_cfg_rd     = rd_q;
  assign om_ch_sel    = sel_q;
  assign om_ch_wdata  = wdata_q;
  assign o_ch_wr_req  = req_q;
  assign om_fail_ch   = fail_ch_q;
  assign om_fail_code = fail_code_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_ao_ini_seq.sv
// Bench for ao_ini_seq: RAM and channel responders driven from per-attempt
// scenario tables, with a cycle timeline model built from the sequencing rules.
module tb_ao_ini_seq;
  localparam int CH = 8;
  localparam int AW = 4;
  localparam int TO = 10;
  localparam int RT = 2;
  localparam int W  = 35;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_ini_start = 1'b0;
  logic          o_ini_done, o_ini_fail, o_busy, o_cfg_rd, o_ch_wr_req;
  logic [AW-1:0] om_cfg_raddr, om_ch_sel, om_fail_ch;
  logic [15:0]   im_cfg_rdata, om_ch_wdata, im_ch_rback;
  logic          i_ch_wr_ack;
  logic [1:0]    om_fail_code;
  logic [3:0]    o_dbg_state;

  ao_ini_seq #(.CH_NUM(CH), .ADDR_W(AW), .TO_CYC(TO), .RETRY(RT)) dut (
    .clk(clk), .rst_n(rst_n), .i_ini_start(i_ini_start),
    .o_ini_done(o_ini_done), .o_ini_fail(o_ini_fail), .o_busy(o_busy),
    .om_cfg_raddr(om_cfg_raddr), .o_cfg_rd(o_cfg_rd), .im_cfg_rdata(im_cfg_rdata),
    .om_ch_sel(om_ch_sel), .om_ch_wdata(om_ch_wdata), .o_ch_wr_req(o_ch_wr_req),
    .i_ch_wr_ack(i_ch_wr_ack), .im_ch_rback(im_ch_rback),
    .om_fail_ch(om_fail_ch), .om_fail_code(om_fail_code), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  idle_v = '0;
  logic [15:0]   ram [16];
  int            sc_delay [CH][RT+1];
  bit            sc_mis [CH][RT+1];
  int            att_cnt [CH];
  logic [AW-1:0] m_raddr = '0, m_sel = '0, m_fch = '0;
  logic [15:0]   m_wd = '0;
  logic [1:0]    m_fcode = '0;
  bit            mon_en = 0, noise_en = 0;
  int            chk_cnt = 0, pass_cnt = 0;
  int            done_cnt, fail_cnt, done_cyc, fail_cyc;
  int            rd_cnt [16];
  int            run_cnt [16], run_sum [16], run_last [16];
  int            run_len = 0;
  logic [AW-1:0] run_sel = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [W-1:0] out_vec();
    return {o_busy, o_cfg_rd, om_cfg_raddr, o_ch_wr_req, om_ch_sel, om_ch_wdata,
            o_ini_done, o_ini_fail, om_fail_ch, om_fail_code};
  endfunction

  function automatic logic [W-1:0] mk(bit busy, bit rd, bit req, bit dn, bit fl);
    return {busy, rd, m_raddr, req, m_sel, m_wd, dn, fl, m_fch, m_fcode};
  endfunction

  // Timeline model: one entry per cycle after the start cycle.
  task automatic build_model(output int len);
    bit ok, failed;
    logic [1:0] code;
    int d;
    failed = 0;
    code = 2'b00;
    m_fch = '0;
    m_fcode = '0;
    for (int c = 0; c < CH && !failed; c++) begin
      m_raddr = AW'(c);
      ok = 0;
      for (int a = 0; a <= RT && !ok; a++) begin
        if (a > 0) exp_q.push_back(mk(1, 0, 0, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0));
        m_sel = AW'(c);
        m_wd = ram[c];
        d = sc_delay[c][a];
        if (d < 0) begin
          repeat (TO) exp_q.push_back(mk(1, 0, 1, 0, 0));
          code = 2'b01;
        end else begin
          repeat (d + 1) exp_q.push_back(mk(1, 0, 1, 0, 0));
          exp_q.push_back(mk(1, 0, 0, 0, 0));
          if (sc_mis[c][a]) code = 2'b10;
          else ok = 1;
        end
      end
      if (ok) begin
        exp_q.push_back(mk(1, 0, 0, 0, 0));
      end else begin
        exp_q.push_back(mk(1, 0, 0, 0, 0));
        m_fch = AW'(c);
        m_fcode = code;
        exp_q.push_back(mk(1, 0, 0, 0, 1));
        failed = 1;
      end
    end
    if (!failed) exp_q.push_back(mk(1, 0, 0, 1, 0));
    idle_v = mk(0, 0, 0, 0, 0);
    len = exp_q.size();
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [W-1:0] ev;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : idle_v;
        check("cycle_outputs", out_vec(), ev);
        if (o_ini_done) begin done_cnt++; done_cyc = cyc; end
        if (o_ini_fail) begin fail_cnt++; fail_cyc = cyc; end
        if (o_cfg_rd) rd_cnt[om_cfg_raddr]++;
        if (o_ch_wr_req) begin
          if (run_len == 0) run_sel = om_ch_sel;
          run_len++;
        end else if (run_len > 0) begin
          run_cnt[run_sel]++;
          run_sum[run_sel] += run_len;
          run_last[run_sel] = run_len;
          run_len = 0;
        end
      end
    end
  end

  // ---------------- RAM / channel responder ----------------
  initial begin
    bit prev_rd;
    logic [AW-1:0] prev_a;
    int rlen, att, s;
    prev_rd = 0; prev_a = '0; rlen = 0; att = 0;
    i_ch_wr_ack = 1'b0; im_ch_rback = '0; im_cfg_rdata = '0;
    forever begin
      @(negedge clk);
      i_ch_wr_ack = 1'b0;
      im_ch_rback = 16'($urandom);
      im_cfg_rdata = prev_rd ? ram[prev_a] : 16'($urandom);
      prev_rd = o_cfg_rd;
      prev_a = om_cfg_raddr;
      if (o_ch_wr_req) begin
        s = (int'(om_ch_sel) < CH) ? int'(om_ch_sel) : 0;
        if (rlen == 0) begin
          att = (att_cnt[s] > RT) ? RT : att_cnt[s];
          att_cnt[s]++;
        end
        rlen++;
        if (sc_delay[s][att] == rlen - 1) begin
          i_ch_wr_ack = 1'b1;
          im_ch_rback = sc_mis[s][att] ? (ram[s] ^ 16'h0100) : ram[s];
        end
      end else begin
        rlen = 0;
        if (noise_en && $urandom_range(0, 3) == 0) i_ch_wr_ack = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    mon_en = 1;
    exp_q.delete();
    m_raddr = '0; m_sel = '0; m_wd = '0; m_fch = '0; m_fcode = '0;
    idle_v = '0;
    #1;
    check("reset_outputs_zero", out_vec(), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_stats();
    done_cnt = 0; fail_cnt = 0; done_cyc = -1; fail_cyc = -1;
    for (int i = 0; i < 16; i++) begin
      rd_cnt[i] = 0; run_cnt[i] = 0; run_sum[i] = 0; run_last[i] = 0;
    end
    for (int i = 0; i < CH; i++) att_cnt[i] = 0;
  endtask

  task automatic clear_sc();
    for (int c = 0; c < CH; c++)
      for (int a = 0; a <= RT; a++) begin
        sc_delay[c][a] = 0;
        sc_mis[c][a] = 0;
      end
  endtask

  // noise_off / rst_off: 0 none, -1 random, >0 cycle offset after start.
  task automatic run_seq(input int noise_off, input int rst_off, output int t0);
    int len, n_off, r_off;
    clear_stats();
    build_model(len);
    n_off = (noise_off < 0) ? $urandom_range(1, len) : noise_off;
    r_off = (rst_off < 0) ? $urandom_range(1, len) : rst_off;
    t0 = cyc;
    i_ini_start = 1'b1;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      i_ini_start = (k == n_off && k <= len);
      if (k == r_off) begin
        i_ini_start = 1'b0;
        do_reset();
        break;
      end
    end
    i_ini_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    for (int n = 0; n < 16; n++) ram[n] = 16'hA500 + 16'(n);
    clear_sc();
    clear_stats();
    @(negedge clk);
    do_reset();
    idle(2);

    // Baseline: zero-wait acks.
    run_seq(0, 0, t0);
    check("base_done_cnt", done_cnt, 1);
    check("base_done_cycle", done_cyc - t0, 41);
    check("base_fail_cnt", fail_cnt, 0);
    for (int c = 0; c < CH; c++) check("base_write_per_ch", run_cnt[c], 1);

    noise_en = 1;
    // Ack delayed 3 cycles on channel 2.
    clear_sc();
    sc_delay[2][0] = 3;
    run_seq(0, 0, t0);
    check("delay_req_len", run_last[2], 4);
    check("delay_done_cycle", done_cyc - t0, 44);

    // Channel 5 never acks.
    clear_sc();
    for (int a = 0; a <= RT; a++) sc_delay[5][a] = -1;
    run_seq(0, 0, t0);
    check("to_req_runs", run_cnt[5], 3);
    check("to_req_cycles", run_sum[5], 30);
    check("to_fail_cnt", fail_cnt, 1);
    check("to_fail_cycle", fail_cyc - t0, 65);
    check("to_done_cnt", done_cnt, 0);
    check("to_fail_ch", om_fail_ch, 5);
    check("to_fail_code", om_fail_code, 2'b01);
    check("to_ch6_7_unwritten", run_cnt[6] + run_cnt[7], 0);

    // Channel 3 readback mismatch on the first attempt only.
    clear_sc();
    sc_mis[3][0] = 1;
    run_seq(0, 0, t0);
    check("mis_rd_addr3", rd_cnt[3], 2);
    check("mis_done_cnt", done_cnt, 1);
    check("mis_done_cycle", done_cyc - t0, 46);
    check("mis_fail_code", om_fail_code, 2'b00);

    // Start pulse while busy is ignored.
    clear_sc();
    run_seq(10, 0, t0);
    idle(5);
    check("busy_start_done_cnt", done_cnt, 1);
    check("busy_start_done_cycle", done_cyc - t0, 41);

    // Reset during WR of channel 4, then a fresh start.
    run_seq(0, 23, t0);
    idle(50);
    check("rst_no_done", done_cnt, 0);
    check("rst_no_fail", fail_cnt, 0);
    run_seq(0, 0, t0);
    check("restart_rd_addr0", rd_cnt[0], 1);
    check("restart_done_cycle", done_cyc - t0, 41);

    // Ack on the final timeout cycle wins.
    clear_sc();
    sc_delay[1][0] = TO - 1;
    run_seq(0, 0, t0);
    check("edge_no_retry", rd_cnt[1], 1);
    check("edge_req_len", run_last[1], TO);
    check("edge_done_cycle", done_cyc - t0, 41 + TO - 1);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      for (int n = 0; n < 16; n++) ram[n] = 16'($urandom);
      for (int c = 0; c < CH; c++)
        for (int a = 0; a <= RT; a++) begin
          int p;
          p = $urandom_range(0, 99);
          if (p < 6) sc_delay[c][a] = -1;
          else if (p < 70) sc_delay[c][a] = 0;
          else sc_delay[c][a] = $urandom_range(0, TO - 1);
          sc_mis[c][a] = ($urandom_range(0, 99) < 8);
        end
      run_seq(($urandom_range(0, 1) == 1) ? -1 : 0,
              ($urandom_range(0, 19) == 0) ? -1 : 0, t0);
      idle($urandom_range(0, 3));
    end

    idle(3);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
